// File: rtl/vga_sync_decoder.sv
//------------------------------------------------------------------------------
// Module      : vga_sync_decoder
// Description : Receive-side VGA timing decoder. Samples the hsync/vsync/RGB
//               pins, recovers pixel coordinates, a per-pixel valid strobe and
//               colour, checks line/frame lengths against the nominal timing
//               and reports lock state and timing errors.
//
// Ports       : vga_clock      - pixel clock (single clock domain)
//               reset          - asynchronous, active-high reset
//               hsync, vsync   - sync inputs from pins
//               vga_red/green/blue - 4-bit colour inputs from pins
//               pixel_valid    - recovered pixel strobe (locked, active area)
//               column, row    - recovered coordinates (0 when not valid)
//               red/green/blue - colour registered with pixel_valid
//               frame_start    - pulse with pixel (row 0, column 0)
//               locked         - timing locked
//               h_error        - 1-cycle line-length error pulse (while locked)
//               v_error        - 1-cycle frame-length error pulse (while locked)
//               frame_checksum - checksum of the last fully locked frame
//               checksum_valid - 1-cycle pulse on checksum update
//
// Options     : VGA_SYNC_DECODER_CHECKSUM_EN - enables the per-frame RGB
//               checksum; when undefined frame_checksum/checksum_valid are 0.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_decoder #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  vga_red,
    input  logic [3:0]  vga_green,
    input  logic [3:0]  vga_blue,
    output logic        pixel_valid,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start,
    output logic        locked,
    output logic        h_error,
    output logic        v_error,
    output logic [15:0] frame_checksum,
    output logic        checksum_valid
);

    localparam logic [31:0] c_h_total = 32'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [31:0] c_v_total = 32'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [31:0] c_hs      = 32'(H_SYNC + H_BACK);
    localparam logic [31:0] c_vs      = 32'(V_SYNC + V_BACK);
    localparam logic [31:0] c_h_act   = 32'(H_ACTIVE);
    localparam logic [31:0] c_v_act   = 32'(V_ACTIVE);

    localparam logic [1:0] c_st_search  = 2'd0;
    localparam logic [1:0] c_st_acquire = 2'd1;
    localparam logic [1:0] c_st_locked  = 2'd2;

    // Two-stage pin capture; s2 is the data the counters are aligned to.
    logic        r_hs_s1, r_vs_s1, r_hs_s2, r_vs_s2;
    logic [11:0] r_rgb_s1, r_rgb_s2;

    logic [31:0] r_h_cnt;
    logic [31:0] r_v_cnt;
    logic        r_h_to_seen;
    logic [1:0]  r_state;

    logic        r_pixel_valid;
    logic [31:0] r_column, r_row;
    logic [11:0] r_rgb_out;
    logic        r_frame_start;
    logic        r_h_error, r_v_error;

    logic        w_hs_act_s1, w_hs_act_s2, w_vs_act_s1, w_vs_act_s2;
    logic        w_hs_edge, w_vs_edge;
    logic        w_h_timeout, w_line_err, w_frame_err, w_any_err;
    logic [31:0] w_v_cnt_chk;
    logic        w_h_win, w_v_win, w_pix_valid;
    logic [31:0] w_column, w_row;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_hs_s1  <= 1'b0;
            r_vs_s1  <= 1'b0;
            r_hs_s2  <= 1'b0;
            r_vs_s2  <= 1'b0;
            r_rgb_s1 <= '0;
            r_rgb_s2 <= '0;
        end else begin
            r_hs_s1  <= hsync;
            r_vs_s1  <= vsync;
            r_hs_s2  <= r_hs_s1;
            r_vs_s2  <= r_vs_s1;
            r_rgb_s1 <= {vga_red, vga_green, vga_blue};
            r_rgb_s2 <= r_rgb_s1;
        end
    end

    // Polarity-normalised sync levels; an assert edge is s1 active, s2 idle.
    assign w_hs_act_s1 = r_hs_s1 ^ SYNC_ACTIVE_LOW;
    assign w_hs_act_s2 = r_hs_s2 ^ SYNC_ACTIVE_LOW;
    assign w_vs_act_s1 = r_vs_s1 ^ SYNC_ACTIVE_LOW;
    assign w_vs_act_s2 = r_vs_s2 ^ SYNC_ACTIVE_LOW;
    assign w_hs_edge   = w_hs_act_s1 & ~w_hs_act_s2;
    assign w_vs_edge   = w_vs_act_s1 & ~w_vs_act_s2;

    // Timeout fires on the first cycle the saturated count is seen; a late
    // edge landing on that same cycle folds into the same single error.
    assign w_h_timeout = (r_h_cnt == c_h_total) && !r_h_to_seen;
    assign w_line_err  = (w_hs_edge && (r_h_cnt != c_h_total - 32'd1)) || w_h_timeout;

    // A coincident hsync edge still counts toward the frame being closed.
    assign w_v_cnt_chk = r_v_cnt + 32'(w_hs_edge);
    assign w_frame_err = (w_vs_edge && (w_v_cnt_chk != c_v_total)) ||
                         (w_hs_edge && !w_vs_edge && (r_v_cnt == c_v_total));
    assign w_any_err   = w_line_err | w_frame_err;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_h_cnt     <= '0;
            r_h_to_seen <= 1'b0;
            r_v_cnt     <= '0;
        end else begin
            if (w_hs_edge) begin
                r_h_cnt     <= '0;
                r_h_to_seen <= 1'b0;
            end else begin
                if (r_h_cnt != c_h_total) begin
                    r_h_cnt <= r_h_cnt + 32'd1;
                end
                if (w_h_timeout) begin
                    r_h_to_seen <= 1'b1;
                end
            end
            // Saturating one past the frame length makes the frame timeout
            // a single transition rather than a repeating condition.
            if (w_vs_edge) begin
                r_v_cnt <= '0;
            end else if (w_hs_edge && (r_v_cnt != c_v_total + 32'd1)) begin
                r_v_cnt <= r_v_cnt + 32'd1;
            end
        end
    end

    assign w_h_win     = (r_h_cnt >= c_hs) && (r_h_cnt < c_hs + c_h_act);
    assign w_v_win     = (r_v_cnt >= c_vs) && (r_v_cnt < c_vs + c_v_act);
    assign w_pix_valid = (r_state == c_st_locked) && w_h_win && w_v_win;
    assign w_column    = r_h_cnt - c_hs;
    assign w_row       = r_v_cnt - c_vs;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_search;
            r_h_error <= 1'b0;
            r_v_error <= 1'b0;
        end else begin
            r_h_error <= (r_state == c_st_locked) && w_line_err;
            r_v_error <= (r_state == c_st_locked) && w_frame_err;
            case (r_state)
                c_st_search: begin
                    if (w_vs_edge) begin
                        r_state <= c_st_acquire;
                    end
                end
                c_st_acquire: begin
                    if (w_any_err) begin
                        r_state <= c_st_search;
                    end else if (w_vs_edge) begin
                        r_state <= c_st_locked;
                    end
                end
                c_st_locked: begin
                    if (w_any_err) begin
                        r_state <= c_st_search;
                    end
                end
                default: r_state <= c_st_search;
            endcase
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_pixel_valid <= 1'b0;
            r_column      <= '0;
            r_row         <= '0;
            r_rgb_out     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pixel_valid <= w_pix_valid;
            r_column      <= w_pix_valid ? w_column : '0;
            r_row         <= w_pix_valid ? w_row : '0;
            r_rgb_out     <= w_pix_valid ? r_rgb_s2 : '0;
            r_frame_start <= w_pix_valid && (w_column == '0) && (w_row == '0);
        end
    end

    assign pixel_valid = r_pixel_valid;
    assign column      = r_column;
    assign row         = r_row;
    assign red         = r_rgb_out[11:8];
    assign green       = r_rgb_out[7:4];
    assign blue        = r_rgb_out[3:0];
    assign frame_start = r_frame_start;
    assign locked      = (r_state == c_st_locked);
    assign h_error     = r_h_error;
    assign v_error     = r_v_error;

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    logic [15:0] r_accum;
    logic [15:0] r_checksum;
    logic        r_checksum_valid;
    // Set when a frame opens with the FSM (remaining or becoming) locked;
    // any error drops it, so only frames spent wholly in LOCKED publish.
    logic        r_frame_locked;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_accum          <= '0;
            r_checksum       <= '0;
            r_checksum_valid <= 1'b0;
            r_frame_locked   <= 1'b0;
        end else begin
            r_checksum_valid <= 1'b0;
            if (w_vs_edge || w_any_err) begin
                r_accum <= '0;
            end else if (w_pix_valid) begin
                r_accum <= r_accum + {4'b0000, r_rgb_s2};
            end
            if (w_vs_edge) begin
                if (r_frame_locked && (r_state == c_st_locked) && !w_any_err) begin
                    r_checksum       <= r_accum;
                    r_checksum_valid <= 1'b1;
                end
                r_frame_locked <= !w_any_err &&
                                  ((r_state == c_st_acquire) || (r_state == c_st_locked));
            end else if (w_any_err) begin
                r_frame_locked <= 1'b0;
            end
        end
    end

    assign frame_checksum = r_checksum;
    assign checksum_valid = r_checksum_valid;
`else
    assign frame_checksum = 16'h0000;
    assign checksum_valid = 1'b0;
`endif

endmodule

`default_nettype wire
